// File: rtl/console_uart_pkg.sv
// Shared constants and types for the console UART transmitter.
// STATUS bit 3 is populated only when CONSOLE_IRQ_EN is defined.
package console_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_IRQ     = 3;
  localparam int STAT_LVL_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/console_uart_fifo.sv
// Byte FIFO with wrap-bit pointers; level = wr - rd over 2*DEPTH.
// Pushes when full and pops when empty are ignored.
module console_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  import console_uart_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        push_s;
  logic        pop_s;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign level_o = wr_q - rd_q;
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;

  // Pointer update
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_s) wr_q <= wr_q + (AW+1)'(1);
      if (pop_s)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/console_uart_tx.sv
// Memory-mapped 8N1 console transmitter on the picorv32 native bus.
// Define CONSOLE_IRQ_EN to add the irq_txe output and STATUS bit 3.
module console_uart_tx #(
  parameter logic [31:0]      ADDR_BASE  = 32'h1000_0000,
  parameter int               FIFO_DEPTH = 16,
  parameter int               DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RESET  = DIV_W'(16'd868)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
`ifdef CONSOLE_IRQ_EN
  ,
  output logic        irq_txe
`endif
);
  import console_uart_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic             mem_ready_q;
  logic [31:0]      mem_rdata_q;
  logic [DIV_W-1:0] div_q, div_d;

  tx_state_e        state_q;
  logic [7:0]       shreg_q;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic             tx_q;
  logic             irq_s;

  logic             sel_s, is_wr_s, data_wr_s, ack_s, push_s, pop_s, cnt_end_s;
  logic [1:0]       off_s;
  logic [31:0]      status_s, rdata_s;
  logic [7:0]       fifo_rdata_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [LW-1:0]    fifo_level_s;
  logic [8:0]       level9_s;
  logic             unused_s;

  console_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push_s),
    .wdata_i (mem_wdata[7:0]),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level_s)
  );

  assign level9_s  = 9'(fifo_level_s);
  assign pop_s     = (state_q == IDLE) && !fifo_empty_s;
  assign cnt_end_s = (cnt_q == period_q - DIV_W'(1));
  assign unused_s  = ^{mem_addr[1:0], mem_wdata, level9_s[8]};

  // Bus decode: a DATA push into a full FIFO is held off until a slot frees
  always_comb begin
    sel_s     = mem_valid && !mem_ready_q && (mem_addr[31:4] == ADDR_BASE[31:4]);
    off_s     = mem_addr[3:2];
    is_wr_s   = (mem_wstrb != 4'b0000);
    data_wr_s = sel_s && (off_s == REG_DATA) && mem_wstrb[0];
    ack_s     = sel_s && !(data_wr_s && fifo_full_s);
    push_s    = ack_s && data_wr_s;

    status_s = 32'h0000_0000;
    status_s[STAT_BUSY]  = (state_q != IDLE);
    status_s[STAT_EMPTY] = fifo_empty_s;
    status_s[STAT_FULL]  = fifo_full_s;
    status_s[STAT_IRQ]   = irq_s;
    status_s[STAT_LVL_LSB +: 8] = level9_s[7:0];

    case (off_s)
      REG_STATUS: rdata_s = status_s;
      REG_DIV:    rdata_s = 32'(div_q);
      default:    rdata_s = 32'h0000_0000;
    endcase

    div_d = div_q;
    if (ack_s && (off_s == REG_DIV)) begin
      for (int b = 0; b < DIV_W; b++) begin
        if (mem_wstrb[b/8]) div_d[b] = mem_wdata[b];
        else                div_d[b] = div_q[b];
      end
    end else begin
      div_d = div_q;
    end
  end

  // Bus response and divider register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0000_0000;
      div_q       <= DIV_RESET;
    end else begin
      mem_ready_q <= ack_s;
      mem_rdata_q <= (ack_s && !is_wr_s) ? rdata_s : 32'h0000_0000;
      div_q       <= div_d;
    end
  end

  // Serializer; the line register trails the state by one cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      shreg_q  <= 8'h00;
      period_q <= DIV_W'(1);
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      tx_q     <= 1'b1;
    end else begin
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shreg_q[0];
        default: tx_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          if (!fifo_empty_s) begin
            shreg_q  <= fifo_rdata_s;
            period_q <= (div_q == '0) ? DIV_W'(1) : div_q;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            state_q  <= START;
          end else begin
            state_q  <= IDLE;
          end
        end
        START: begin
          if (cnt_end_s) begin
            cnt_q   <= '0;
            state_q <= DATA;
          end else begin
            cnt_q   <= cnt_q + DIV_W'(1);
          end
        end
        DATA: begin
          if (cnt_end_s) begin
            cnt_q   <= '0;
            shreg_q <= {1'b0, shreg_q[7:1]};
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q   <= cnt_q + DIV_W'(1);
          end
        end
        STOP: begin
          if (cnt_end_s) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CONSOLE_IRQ_EN
  logic irq_q;

  // Transmitter-empty level
  always_ff @(posedge clk) begin
    if (!resetn) irq_q <= 1'b0;
    else         irq_q <= fifo_empty_s && (state_q == IDLE);
  end

  assign irq_s   = irq_q;
  assign irq_txe = irq_q;
`else
  assign irq_s = 1'b0;
`endif

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign uart_tx   = tx_q;

endmodule
